// File: rtl/can_crc_engine.sv
// Serial CRC-15/17/21 engine for the CAN / CAN FD bit stream: per-frame mode,
// stuff-bit handling, zero-residue flag and MSB-first serialisation of the result.
module can_crc_engine #(
   parameter int          CRC_W      = 21,
   parameter logic [14:0] POLY15     = 15'h4599,
   parameter logic [16:0] POLY17     = 17'h1685B,
   parameter logic [20:0] POLY21     = 21'h102899,
   parameter bit          FD_INIT_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             crc_init,
   input  logic [1:0]       mode,
   input  logic             bit_valid,
   input  logic             data_bit,
   input  logic             stuff_bit,
   input  logic             shift_start,
   input  logic             shift_adv,
   output logic [CRC_W-1:0] crc_out,
   output logic [4:0]       crc_len,
   output logic             crc_zero,
   output logic             tx_bit,
   output logic             tx_active,
   output logic             tx_last,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, CALC, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {M15, M17, M21}           crc_mode_t;

   state_t           state;
   crc_mode_t        mode_q;
   logic [CRC_W-1:0] crc_reg;
   logic [CRC_W-1:0] shift_reg;
   logic [4:0]       cnt;

   function automatic logic [4:0] len_of(input crc_mode_t m);
      case (m)
         M17:     return 5'd17;
         M21:     return 5'd21;
         default: return 5'd15;
      endcase
   endfunction

   function automatic logic [CRC_W-1:0] poly_of(input crc_mode_t m);
      case (m)
         M17:     return CRC_W'(POLY17);
         M21:     return CRC_W'(POLY21);
         default: return CRC_W'(POLY15);
      endcase
   endfunction

   // CAN FD CRCs seed a single one in the top bit of the active width.
   function automatic logic [CRC_W-1:0] init_of(input crc_mode_t m);
      if (!FD_INIT_EN || m == M15) return '0;
      return CRC_W'(1) << (len_of(m) - 5'd1);
   endfunction

   function automatic crc_mode_t decode_mode(input logic [1:0] m);
      case (m)
         2'd1:    return M17;
         2'd2:    return M21;
         default: return M15;
      endcase
   endfunction

   logic [CRC_W-1:0] len_mask;
   logic [CRC_W-1:0] crc_next;
   logic             fb;
   logic             take_bit;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      crc_len  = len_of(mode_q);
      len_mask = (CRC_W'(1) << crc_len) - CRC_W'(1);
      fb       = data_bit ^ crc_reg[crc_len - 5'd1];
      crc_next = ((crc_reg << 1) & len_mask) ^ (fb ? poly_of(mode_q) : '0);
      take_bit = bit_valid && !(mode_q == M15 && stuff_bit);
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mode_q    <= M15;
         crc_reg   <= '0;
         shift_reg <= '0;
         cnt       <= '0;
      end else if (crc_init) begin
         state     <= CALC;
         mode_q    <= decode_mode(mode);
         crc_reg   <= init_of(decode_mode(mode));
         shift_reg <= '0;
         cnt       <= '0;
      end else begin
         case (state)
            CALC: begin
               if (shift_start) begin
                  shift_reg <= crc_reg;
                  cnt       <= crc_len - 5'd1;
                  state     <= SHIFT;
               end else if (take_bit) begin
                  crc_reg <= crc_next;
               end
            end
            SHIFT: begin
               if (shift_adv) begin
                  shift_reg <= (shift_reg << 1) & len_mask;
                  if (cnt == 5'd0) state <= DONE;
                  else             cnt   <= cnt - 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign crc_out   = crc_reg;
   assign crc_zero  = ((crc_reg & len_mask) == '0);
   assign tx_active = (state == SHIFT);
   assign tx_bit    = tx_active && shift_reg[crc_len - 5'd1];
   assign tx_last   = tx_active && (cnt == 5'd0);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_can_crc_engine.sv
// Scoreboard bench for can_crc_engine: stimulus queues expected snapshots and
// serial bits; monitors compare them on the falling edge.
module tb_can_crc_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        crc_init;
   logic [1:0]  mode;
   logic        bit_valid, data_bit, stuff_bit, shift_start, shift_adv;
   logic [20:0] crc_out;
   logic [4:0]  crc_len;
   logic        crc_zero, tx_bit, tx_active, tx_last, busy;

   can_crc_engine dut (
      .clk(clk), .rst(rst), .crc_init(crc_init), .mode(mode),
      .bit_valid(bit_valid), .data_bit(data_bit), .stuff_bit(stuff_bit),
      .shift_start(shift_start), .shift_adv(shift_adv),
      .crc_out(crc_out), .crc_len(crc_len), .crc_zero(crc_zero),
      .tx_bit(tx_bit), .tx_active(tx_active), .tx_last(tx_last), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          due;
      logic [20:0] crc;
      logic [4:0]  len;
      logic        zero;
      logic        busy;
      logic        act;
   } snap_t;

   typedef struct {
      logic b;
      logic last;
   } txexp_t;

   snap_t  exp_q[$];
   txexp_t tx_q[$];
   int     cyc = 0;
   int     total = 0;
   int     bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Snapshot monitor.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         snap_t e;
         e = exp_q.pop_front();
         if (e.due < cyc) check({e.name, "_late"}, 32'(cyc), 32'(e.due));
         else begin
            check({e.name, "_crc"},  32'(crc_out),   32'(e.crc));
            check({e.name, "_len"},  32'(crc_len),   32'(e.len));
            check({e.name, "_zero"}, 32'(crc_zero),  32'(e.zero));
            check({e.name, "_busy"}, 32'(busy),      32'(e.busy));
            check({e.name, "_act"},  32'(tx_active), 32'(e.act));
            if (!e.act) begin
               check({e.name, "_txbit"},  32'(tx_bit),  32'd0);
               check({e.name, "_txlast"}, 32'(tx_last), 32'd0);
            end
         end
      end
   end

   // Serial-output monitor: every cycle with tx_active consumes one expected bit.
   always @(negedge clk) begin
      if (tx_active) begin
         if (tx_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
         else begin
            txexp_t t;
            t = tx_q.pop_front();
            check("tx_bit",  32'(tx_bit),  32'(t.b));
            check("tx_last", 32'(tx_last), 32'(t.last));
         end
      end
   end

   task automatic expect_at(input string n, input int dly, input logic [20:0] c,
                            input logic [4:0] l, input logic z, input logic b, input logic a);
      snap_t e;
      e.name = n; e.due = cyc + dly; e.crc = c; e.len = l; e.zero = z; e.busy = b; e.act = a;
      exp_q.push_back(e);
   endtask

   task automatic expect_tx(input logic [14:0] pat, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         txexp_t t;
         t.b = pat[14 - i];
         t.last = (i == 14);
         tx_q.push_back(t);
      end
   endtask

   task automatic drive(input logic i, input logic [1:0] m, input logic bv, input logic db,
                        input logic sb, input logic ss, input logic adv);
      crc_init = i; mode = m; bit_valid = bv; data_bit = db; stuff_bit = sb;
      shift_start = ss; shift_adv = adv;
      @(posedge clk);
      #1;
   endtask

   task automatic init(input logic [1:0] m); drive(1, m, 0, 0, 0, 0, 0); endtask
   task automatic feed(input logic db, input logic sb); drive(0, 2'd0, 1, db, sb, 0, 0); endtask
   task automatic idle(); drive(0, 2'd0, 0, 0, 0, 0, 0); endtask

   logic [14:0] crc15_of_one;

   initial begin
      crc15_of_one = 15'b100010110011001;
      rst = 1'b1;
      crc_init = 0; mode = 0; bit_valid = 0; data_bit = 0; stuff_bit = 0;
      shift_start = 0; shift_adv = 0;
      repeat (2) @(posedge clk);
      #1;
      expect_at("reset", 0, 21'h0, 5'd15, 1, 0, 0);
      rst = 1'b0;

      // Basic update in each mode, including FD init values.
      expect_at("init15", 1, 21'h0, 5'd15, 1, 1, 0);        init(2'd0);
      expect_at("c15_bit1", 1, 21'h4599, 5'd15, 0, 1, 0);   feed(1, 0);
      expect_at("init17", 1, 21'h10000, 5'd17, 0, 1, 0);    init(2'd1);
      expect_at("c17_bit0", 1, 21'h1685B, 5'd17, 0, 1, 0);  feed(0, 0);
      expect_at("init21", 1, 21'h100000, 5'd21, 0, 1, 0);   init(2'd2);
      expect_at("c21_bit0", 1, 21'h102899, 5'd21, 0, 1, 0); feed(0, 0);
      expect_at("init_m3", 1, 21'h0, 5'd15, 1, 1, 0);       init(2'd3);
      expect_at("m3_bit1", 1, 21'h4599, 5'd15, 0, 1, 0);    feed(1, 0);

      // Stuff-bit handling.
      init(2'd0);
      expect_at("stuff15", 1, 21'h0, 5'd15, 1, 1, 0);       feed(1, 1);
      init(2'd1);
      expect_at("stuff17_d1", 1, 21'h0, 5'd17, 1, 1, 0);    feed(1, 1);
      init(2'd1);
      expect_at("stuff17_d0", 1, 21'h1685B, 5'd17, 0, 1, 0); feed(0, 1);

      // crc_init beats a simultaneous bit.
      feed(1, 0);
      expect_at("init_wins", 1, 21'h100000, 5'd21, 0, 1, 0); drive(1, 2'd2, 1, 0, 0, 0, 0);
      expect_at("init_hold", 1, 21'h100000, 5'd21, 0, 1, 0); idle();

      // Full serialisation of 15'h4599.
      init(2'd0);
      feed(1, 0);
      expect_tx(crc15_of_one, 15);
      expect_at("shift_go", 1, 21'h4599, 5'd15, 0, 1, 1);   drive(0, 2'd0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 15; i++) begin
         if (i == 14) expect_at("done", 1, 21'h4599, 5'd15, 0, 1, 0);
         drive(0, 2'd0, 0, 0, 0, 0, 1);
      end
      expect_at("done_bv", 1, 21'h4599, 5'd15, 0, 1, 0);    feed(1, 0);
      expect_at("done_ss", 1, 21'h4599, 5'd15, 0, 1, 0);    drive(0, 2'd0, 0, 0, 0, 1, 0);

      // Residue check: data bit 1 followed by its CRC, then a corrupted last bit.
      init(2'd0);
      feed(1, 0);
      for (int i = 14; i >= 0; i--) begin
         if (i == 0) expect_at("residue_ok", 1, 21'h0, 5'd15, 1, 1, 0);
         feed(crc15_of_one[i], 0);
      end
      init(2'd0);
      feed(1, 0);
      for (int i = 14; i >= 0; i--) begin
         if (i == 0) expect_at("residue_bad", 1, 21'h4599, 5'd15, 0, 1, 0);
         feed((i == 0) ? ~crc15_of_one[i] : crc15_of_one[i], 0);
      end

      // Reset on the fifth shift_adv aborts serialisation.
      init(2'd0);
      feed(1, 0);
      expect_tx(crc15_of_one, 5);
      drive(0, 2'd0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) drive(0, 2'd0, 0, 0, 0, 0, 1);
      rst = 1'b1;
      expect_at("rst_mid_shift", 1, 21'h0, 5'd15, 1, 0, 0);
      drive(0, 2'd0, 0, 0, 0, 0, 1);
      rst = 1'b0;
      idle();

      // Bounded drain of both scoreboards.
      for (int i = 0; i < 20 && (exp_q.size() > 0 || tx_q.size() > 0); i++) idle();
      @(negedge clk);
      check("snap_queue_left", 32'(exp_q.size()), 32'd0);
      check("tx_queue_left", 32'(tx_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
